// File: rtl/branch_resolver_if.sv
// Issue, CDB-snoop and branch-broadcast signals of the branch resolver.
//
// Handshakes (valid/ready):
//   issue: a branch transfers on a clock edge where issue_valid && issue_ready
//          (and the global rdy_in is high). issue_ready never depends on
//          issue_valid or on a same-cycle pop.
//   broadcast: br_req is the valid and br_grant the ready; the outcome
//          transfers on an edge where both are high. While br_req is high
//          and not granted, br_addr/br_val stay stable.
//   cdb: broadcast-only (no back-pressure); cdb_active qualifies tag/value.
interface branch_resolver_if #(
  parameter int TAG_W = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [31:0]       issue_pc;
  logic [2:0]        issue_funct3;
  logic [31:0]       issue_vj;
  logic [31:0]       issue_vk;
  logic              issue_qj_busy;
  logic              issue_qk_busy;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic              cdb_active;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_val;
  logic              br_req;
  logic              br_grant;
  logic [31:0]       br_addr;
  logic [31:0]       br_val;

  // Issue stage, CDB and CDB arbiter side
  modport master (
    output issue_valid, issue_pc, issue_funct3, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_active, cdb_tag, cdb_val, br_grant,
    input  issue_ready, br_req, br_addr, br_val
  );

  // Branch resolver side
  modport slave (
    input  issue_valid, issue_pc, issue_funct3, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_active, cdb_tag, cdb_val, br_grant,
    output issue_ready, br_req, br_addr, br_val
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order branch execution buffer. Issued conditional branches wait in a
// circular FIFO, snoop the CDB for pending operands, and only the head entry
// may evaluate and broadcast its outcome, so outcomes leave in program order.
module branch_resolver #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  branch_resolver_if.slave bus
);

  localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);

  // Control state (reset) and payload storage (no reset needed: every
  // payload field is written on push before its valid bit can be seen).
  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH-1:0]   busy_j;
  logic [DEPTH-1:0]   busy_k;
  logic [31:0]        ent_pc [DEPTH];
  logic [2:0]         ent_f3 [DEPTH];
  logic [31:0]        ent_vj [DEPTH];
  logic [31:0]        ent_vk [DEPTH];
  logic [TAG_W-1:0]   ent_qj [DEPTH];
  logic [TAG_W-1:0]   ent_qk [DEPTH];
  logic [DEPTH_W:0]   count;
  logic [DEPTH_W-1:0] front;
  logic [DEPTH_W-1:0] rear;

  logic issue_ready_int;
  logic br_req_int;
  logic head_taken;
  logic push;
  logic pop;
  logic fwd_j;
  logic fwd_k;

  // Branch condition evaluation; funct3 010/011 are not branches -> not taken.
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Handshake qualifiers and same-cycle CDB forwarding for the issuing branch.
  always_comb begin
    issue_ready_int = (count != CNT_FULL) && !flush;
    br_req_int      = rdy_in && !flush && ent_valid[front] &&
                      !busy_j[front] && !busy_k[front];
    head_taken      = br_taken(ent_f3[front], ent_vj[front], ent_vk[front]);
    push            = bus.issue_valid && issue_ready_int && rdy_in;
    pop             = br_req_int && bus.br_grant;
    fwd_j           = bus.issue_qj_busy && bus.cdb_active && (bus.cdb_tag == bus.issue_qj);
    fwd_k           = bus.issue_qk_busy && bus.cdb_active && (bus.cdb_tag == bus.issue_qk);
  end

  // Outputs are forced to zero whenever the head is not requesting.
  always_comb begin
    bus.issue_ready = issue_ready_int;
    bus.br_req      = br_req_int;
    bus.br_addr     = br_req_int ? ent_pc[front] : 32'd0;
    bus.br_val      = {31'd0, br_req_int & head_taken};
  end

  // Control: pointers, occupancy, valid and busy bits; flush wins over all.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_valid <= '0;
      busy_j    <= '0;
      busy_k    <= '0;
      count     <= '0;
      front     <= '0;
      rear      <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        ent_valid <= '0;
        busy_j    <= '0;
        busy_k    <= '0;
        count     <= '0;
        front     <= '0;
        rear      <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i] && bus.cdb_active) begin
            if (busy_j[i] && (ent_qj[i] == bus.cdb_tag)) busy_j[i] <= 1'b0;
            if (busy_k[i] && (ent_qk[i] == bus.cdb_tag)) busy_k[i] <= 1'b0;
          end
        end
        if (push) begin
          ent_valid[rear] <= 1'b1;
          busy_j[rear]    <= bus.issue_qj_busy && !fwd_j;
          busy_k[rear]    <= bus.issue_qk_busy && !fwd_k;
          rear            <= rear + 1'b1;
        end
        if (pop) begin
          ent_valid[front] <= 1'b0;
          front            <= front + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload: operand capture from the CDB and entry write on push.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && bus.cdb_active) begin
          if (busy_j[i] && (ent_qj[i] == bus.cdb_tag)) ent_vj[i] <= bus.cdb_val;
          if (busy_k[i] && (ent_qk[i] == bus.cdb_tag)) ent_vk[i] <= bus.cdb_val;
        end
      end
      if (push) begin
        ent_pc[rear] <= bus.issue_pc;
        ent_f3[rear] <= bus.issue_funct3;
        ent_vj[rear] <= fwd_j ? bus.cdb_val : bus.issue_vj;
        ent_vk[rear] <= fwd_k ? bus.cdb_val : bus.issue_vk;
        ent_qj[rear] <= bus.issue_qj;
        ent_qk[rear] <= bus.issue_qk;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and an expected-outcome
// scoreboard consumed by an independent monitor.
module tb_branch_resolver;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;

  always #5 clk_in = ~clk_in;

  branch_resolver_if #(.TAG_W(TAG_W)) bus();

  branch_resolver #(.DEPTH(DEPTH), .DEPTH_W(3), .TAG_W(TAG_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0]      pc;
    logic             bj;
    logic             bk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } mrec_t;

  mrec_t       mq[$];          // branches the buffer should hold, oldest first
  logic [63:0] exp_q[$];       // expected {br_addr, br_val} in program order
  logic        outstanding[16];
  logic [31:0] fut_val[16];    // value each outstanding tag will deliver

  // per-cycle stimulus
  logic             s_valid, s_bj, s_bk, s_cdb_act, s_grant, s_rdy, s_flush;
  logic [31:0]      s_pc, s_vj, s_vk, s_cdb_val;
  logic [2:0]       s_f3;
  logic [TAG_W-1:0] s_qj, s_qk, s_cdb_tag;

  logic exp_ready, exp_req;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Value an operand will finally hold in the buffer.
  task automatic resolve_op(input logic busy, input logic [TAG_W-1:0] tag,
                            input logic [31:0] v_ready, output logic [31:0] v);
    if (!busy) v = v_ready;
    else if (s_cdb_act && s_cdb_tag == tag) v = s_cdb_val;
    else begin
      if (!outstanding[tag]) begin
        outstanding[tag] = 1'b1;
        fut_val[tag]     = rand_val();
      end
      v = fut_val[tag];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cdb(input logic [TAG_W-1:0] tag);
    s_cdb_act = 1'b1;
    s_cdb_tag = tag;
    s_cdb_val = outstanding[tag] ? fut_val[tag] : $urandom;
  endtask

  task automatic set_issue(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic bj, input logic [TAG_W-1:0] qj,
                           input logic bk, input logic [TAG_W-1:0] qk);
    s_valid = 1'b1;
    s_pc = pc; s_f3 = f3;
    s_bj = bj; s_qj = qj; s_bk = bk; s_qk = qk;
    resolve_op(bj, qj, vj, s_vj);
    resolve_op(bk, qk, vk, s_vk);
  endtask

  // Drive one cycle, record expectations, advance the model past the edge.
  task automatic step();
    int n;
    mrec_t r;
    n = mq.size();
    exp_ready = (n < DEPTH) && !s_flush;
    exp_req   = 1'b0;
    if (s_rdy && !s_flush && n > 0) exp_req = !mq[0].bj && !mq[0].bk;

    rdy_in            = s_rdy;
    flush             = s_flush;
    bus.issue_valid   = s_valid;
    bus.issue_pc      = s_pc;
    bus.issue_funct3  = s_f3;
    bus.issue_vj      = s_bj ? $urandom : s_vj;
    bus.issue_vk      = s_bk ? $urandom : s_vk;
    bus.issue_qj_busy = s_bj;
    bus.issue_qk_busy = s_bk;
    bus.issue_qj      = s_qj;
    bus.issue_qk      = s_qk;
    bus.cdb_active    = s_cdb_act;
    bus.cdb_tag       = s_cdb_tag;
    bus.cdb_val       = s_cdb_val;
    bus.br_grant      = s_grant;
    chk_en            = 1'b1;

    if (s_rdy) begin
      if (s_flush) begin
        mq.delete();
        exp_q.delete();
      end else begin
        if (exp_req && s_grant) void'(mq.pop_front());
        if (s_cdb_act) begin
          foreach (mq[i]) begin
            if (mq[i].bj && mq[i].qj == s_cdb_tag) mq[i].bj = 1'b0;
            if (mq[i].bk && mq[i].qk == s_cdb_tag) mq[i].bk = 1'b0;
          end
        end
        if (s_valid && n < DEPTH) begin
          r.pc = s_pc;
          r.qj = s_qj; r.qk = s_qk;
          r.bj = s_bj && !(s_cdb_act && s_cdb_tag == s_qj);
          r.bk = s_bk && !(s_cdb_act && s_cdb_tag == s_qk);
          mq.push_back(r);
          exp_q.push_back({s_pc, 31'd0, ref_taken(s_f3, s_vj, s_vk)});
        end
      end
      if (s_cdb_act) outstanding[s_cdb_tag] = 1'b0;
    end

    @(posedge clk_in);
    #1;
    s_valid = 1'b0; s_cdb_act = 1'b0; s_flush = 1'b0;
    s_bj = 1'b0; s_bk = 1'b0;
  endtask

  function automatic int pick_outstanding();
    int start;
    start = $urandom_range(0, 15);
    for (int k = 0; k < 16; k++)
      if (outstanding[(start + k) % 16]) return (start + k) % 16;
    return -1;
  endfunction

  task automatic drain(input string name);
    int t;
    s_rdy = 1'b1;
    s_grant = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (mq.size() == 0) break;
      t = pick_outstanding();
      if (t >= 0) set_cdb(TAG_W'(t));
      step();
    end
    check({name, "_model_empty"}, 64'(mq.size()), 64'd0);
    step();
    check({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) outstanding[i] = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    if (chk_en && !rst_in) begin
      check("issue_ready", 64'(bus.issue_ready), 64'(exp_ready));
      check("br_req", 64'(bus.br_req), 64'(exp_req));
      if (bus.br_req) begin
        if (exp_q.size() == 0) begin
          check("br_unexpected", 64'(bus.br_req), 64'd0);
        end else begin
          check("br_outcome", {bus.br_addr, bus.br_val}, exp_q[0]);
          if (bus.br_grant) void'(exp_q.pop_front());
        end
      end else begin
        check("br_idle", {bus.br_addr, bus.br_val}, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    s_valid = 0; s_bj = 0; s_bk = 0; s_cdb_act = 0; s_grant = 1; s_rdy = 1; s_flush = 0;
    s_pc = 0; s_vj = 0; s_vk = 0; s_cdb_val = 0; s_f3 = 0; s_qj = 0; s_qk = 0; s_cdb_tag = 0;
    bus.issue_valid = 0; bus.issue_pc = 0; bus.issue_funct3 = 0; bus.issue_vj = 0;
    bus.issue_vk = 0; bus.issue_qj_busy = 0; bus.issue_qk_busy = 0; bus.issue_qj = 0;
    bus.issue_qk = 0; bus.cdb_active = 0; bus.cdb_tag = 0; bus.cdb_val = 0; bus.br_grant = 0;
    model_reset();

    // reset values
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_br_req", 64'(bus.br_req), 64'd0);
    check("rst_br_out", {bus.br_addr, bus.br_val}, 64'd0);
    check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    rst_in = 1'b0;

    // single ready BEQ, grant tied high
    set_issue(32'h100, 3'd0, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    repeat (3) step();

    // signed vs unsigned compare on the same operands, in order
    set_issue(32'h140, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    set_issue(32'h144, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    repeat (4) step();

    // older branch waits on tag 3, younger ready one must not overtake
    outstanding[3] = 1'b1;
    fut_val[3] = 32'd7;
    set_issue(32'h200, 3'd0, 32'd0, 32'd7, 1'b1, 4'd3, 1'b0, 4'd0);
    step();
    set_issue(32'h204, 3'd1, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    step();
    set_cdb(4'd3);
    step();
    repeat (4) step();

    // operand forwarded from the CDB in the issue cycle
    s_cdb_act = 1'b1; s_cdb_tag = 4'd5; s_cdb_val = 32'd9;
    set_issue(32'h300, 3'd5, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5);
    step();
    repeat (3) step();

    // fill to full with no grant, then pop while issuing so pointers wrap
    s_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_issue(32'h400 + 32'(4 * i), 3'd1, 32'(i), 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
    end
    s_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_issue(32'h500 + 32'(4 * i), 3'd7, 32'(i), 32'd3, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
    end
    drain("fill");

    // flush with simultaneous issue and grant
    s_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(32'h600 + 32'(4 * i), 3'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
    end
    s_grant = 1'b1;
    s_flush = 1'b1;
    set_issue(32'h700, 3'd0, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    repeat (2) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_rdy   = ($urandom_range(0, 9) != 0);
      s_grant = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 59) == 0) s_flush = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        t = pick_outstanding();
        set_cdb(t >= 0 ? TAG_W'(t) : TAG_W'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 9) < 6)
        set_issue($urandom & 32'hFFFF_FFFC, 3'($urandom_range(0, 7)), rand_val(), rand_val(),
                  $urandom_range(0, 2) == 0, TAG_W'($urandom_range(0, 15)),
                  $urandom_range(0, 2) == 0, TAG_W'($urandom_range(0, 15)));
      step();
    end
    drain("random");

    // asynchronous reset while a broadcast is pending
    s_grant = 1'b0;
    set_issue(32'h800, 3'd0, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    step();
    chk_en = 1'b0;
    check("pre_reset_br_req", 64'(bus.br_req), 64'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_br_req", 64'(bus.br_req), 64'd0);
    check("async_rst_br_out", {bus.br_addr, bus.br_val}, 64'd0);
    check("async_rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    s_grant = 1'b1;
    repeat (2) step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- In-order branch execution buffer between the decoder/issue stage and the common data bus (CDB).
- Holds issued conditional branches and snoops the CDB for their source operands.
- Evaluates each branch condition and broadcasts the outcome on the CDB in program order: address = branch PC, value bit 0 = taken.
- This is the producer of the branch-outcome broadcasts that the branch predictor consumes in order from its queue head. Resolution must therefore never reorder branches.

Parameters:
- DEPTH, 8, number of buffered branches (power of two).
- DEPTH_W, 3, log2(DEPTH).
- TAG_W, 4, width of the rename tag identifying a pending operand producer.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; low freezes all state.
- flush  input  1  mispredict flush; discards every buffered branch.
- issue_valid  input  1  a branch is presented this cycle.
- issue_ready  output  1  buffer can accept a branch.
- issue_pc  input  32  branch PC.
- issue_funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- issue_vj, issue_vk  input  32 each  operand values, valid when not busy.
- issue_qj_busy, issue_qk_busy  input  1 each  operand still pending.
- issue_qj, issue_qk  input  TAG_W each  producer tag of the pending operand.
- cdb_active  input  1  CDB carries a result this cycle.
- cdb_tag  input  TAG_W  result tag.
- cdb_val  input  32  result value.
- br_req  output  1  head branch resolved, requests the CDB.
- br_grant  input  1  CDB arbiter grants br_req.
- br_addr  output  32  PC of the broadcast branch.
- br_val  output  32  {31'b0, taken}.

Behaviour:
- Reset, asynchronous: count, front and rear = 0; all entries invalid. Outputs: br_req=0, br_addr=0, br_val=0, issue_ready=1.
- Storage: circular FIFO. Per entry: valid, pc, funct3, vj, vk, busy_j, busy_k, qj, qk.
- issue_ready = (count < DEPTH) && !flush. It does not depend on a same-cycle pop, so a full buffer refuses issue even while popping.
- Push: issue_valid && issue_ready && rdy_in at posedge writes entry[rear]; rear wraps DEPTH-1 -> 0.
- Same-cycle forwarding on push: if busy and cdb_active && cdb_tag == issue tag, the operand is stored as ready with cdb_val.
- Snoop: every rdy_in cycle, each valid entry whose busy operand tag equals cdb_tag (cdb_active=1) captures cdb_val and clears busy. Both operands may capture in the same cycle.
- Resolution, combinational from registered state: br_req = rdy_in && !flush && entry[front].valid && !busy_j && !busy_k. br_addr = entry[front].pc and br_val[0] = taken while br_req is high; both are 0 otherwise.
- Condition: BEQ vj==vk; BNE vj!=vk; BLT/BGE signed; BLTU/BGEU unsigned; funct3 010/011 -> not taken.
- Pop: br_req && br_grant at posedge invalidates entry[front]; front wraps. br_req may stay high across stall cycles. br_addr/br_val hold stable until granted.
- Only the head may broadcast; a ready younger entry waits. Latency from ready operands to br_req is 0 cycles after the capturing edge.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- flush is synchronous and highest priority: all entries invalid, count/front/rear=0. Same-cycle issue and grant are ignored.
- rdy_in=0: no push, pop or snoop capture; br_req=0; state held.
- Reset asserted mid-operation clears everything immediately, regardless of clk_in.

Test Plan:
- Reset, then issue BEQ pc=0x100 with vj=vk=5 ready, grant tied 1 -> br_req high the next cycle with br_addr=0x100, br_val=1; entry pops; br_req drops.
- Issue BLT vj=0xFFFFFFFF vk=1 (taken, br_val=1), then BLTU with the same operands (not taken, br_val=0) -> broadcasts appear in issue order.
- Issue A (pc=0x200, qj=3 busy) then B (pc=0x204, ready); CDB tag 3 val 7 two cycles later -> no br_req for B before A; A broadcasts first, then B.
- Issue with qk=5 busy while cdb_active, tag 5, val 9 in the same cycle -> operand captured; br_req the next cycle.
- Fill 8 entries with grant=0 -> issue_ready=0. Assert grant -> one pop per cycle; rear and front wrap past 7; issue_ready returns to 1 after the first pop.
- 4 entries buffered, assert flush together with issue_valid and br_grant -> count=0, no pop recorded, issued branch discarded, br_req=0 the next cycle. Then assert rst_in asynchronously mid-stream -> outputs 0 before the next clock edge.
